// File: rtl/io_pkg.sv
// Shared definitions for the I/O register bank.
//  - Register offsets are relative to the channel count R, so they are
//    provided as functions of R rather than fixed localparams.
//  - io_clog2 sizes the CPU address bus from the number of registers.
package io_pkg;

    // Smallest n such that 2**n >= value (returns 0 for value <= 1).
    function automatic int io_clog2(input int value);
        int bits;
        bits = 0;
        for (int span = 1; span < value; span = span * 2) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    function automatic int ofs_stat_out(input int r);
        return r;
    endfunction

    function automatic int ofs_stat_in(input int r);
        return r + 1;
    endfunction

    function automatic int ofs_ovr(input int r);
        return r + 2;
    endfunction

    function automatic int ofs_ien(input int r);
        return r + 3;
    endfunction

endpackage

// File: rtl/io_channel.sv
// One bidirectional channel of the I/O register bank.
//  Output side: data register + valid toward the peripheral, overrun flag
//  set when the CPU writes while the previous value is still unconsumed.
//  Input side: data register + full flag, in_ready is simply ~in_full.
// Ports:
//  clk, rst      clock, asynchronous active-low reset
//  wr_sel        CPU write to this channel's DATA register this cycle
//  rd_clr        CPU read of this channel's DATA register this cycle
//  ovr_clr       write-1-to-clear strobe for the overrun bit
//  wdata         CPU write data
//  out_ready     peripheral accepts out_data when out_valid is high
//  in_valid      peripheral offers in_data
//  in_data       peripheral data
//  out_data      output register
//  out_valid     output register holds unconsumed data
//  in_q          input register (last captured value)
//  in_full       input register holds unread data
//  in_full_nxt   value in_full takes at the next edge (feeds irq)
//  ovr           overrun flag
module io_channel
    import io_pkg::*;
#(
    parameter int T = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_sel,
    input  logic         rd_clr,
    input  logic         ovr_clr,
    input  logic [T-1:0] wdata,
    input  logic         out_ready,
    input  logic         in_valid,
    input  logic [T-1:0] in_data,
    output logic [T-1:0] out_data,
    output logic         out_valid,
    output logic [T-1:0] in_q,
    output logic         in_full,
    output logic         in_full_nxt,
    output logic         ovr
);

    logic load;
    logic drop;
    logic capture;
    logic out_valid_nxt;
    logic ovr_nxt;

    always_comb begin
        // A write is accepted if the slot is empty or is being drained this cycle.
        load          = wr_sel & (~out_valid | out_ready);
        drop          = wr_sel & out_valid & ~out_ready;
        capture       = in_valid & ~in_full;
        out_valid_nxt = load | (out_valid & ~out_ready);
        // Capture only happens while empty and rd_clr only matters while full,
        // so the two never compete.
        in_full_nxt   = capture | (in_full & ~rd_clr);
        // A new overrun in the same cycle beats the clear.
        ovr_nxt       = drop | (ovr & ~ovr_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            in_q      <= '0;
            in_full   <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            if (load) begin
                out_data <= wdata;
            end
            if (capture) begin
                in_q <= in_data;
            end
            out_valid <= out_valid_nxt;
            in_full   <= in_full_nxt;
            ovr       <= ovr_nxt;
        end
    end

endmodule

// File: rtl/io_reg_bank.sv
// CPU-addressable bank of R bidirectional T-bit I/O channels.
//  Address map: 0..R-1 DATA[i], R STAT_OUT, R+1 STAT_IN, R+2 OVR (W1C),
//  R+3 IEN. Unmapped addresses read 0 and ignore writes.
//  Reads are registered: cpu_rdata/cpu_rvalid appear the cycle after
//  cpu_re and always reflect the register contents before any write in
//  the same cycle.
// Ports:
//  clk, rst                 clock, asynchronous active-low reset
//  cpu_we, cpu_re           single-cycle write/read strobes
//  cpu_addr, cpu_wdata      register address and write data
//  cpu_rdata, cpu_rvalid    registered read data and its valid
//  out_data/out_valid/out_ready   per-channel output handshake
//  in_data/in_valid/in_ready      per-channel input handshake
//  irq                      level interrupt, any enabled input full
module io_reg_bank
    import io_pkg::*;
#(
    parameter int R = 2,
    parameter int T = 8,
    parameter int A = io_clog2(R + 4)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cpu_we,
    input  logic           cpu_re,
    input  logic [A-1:0]   cpu_addr,
    input  logic [T-1:0]   cpu_wdata,
    output logic [T-1:0]   cpu_rdata,
    output logic           cpu_rvalid,
    output logic [R*T-1:0] out_data,
    output logic [R-1:0]   out_valid,
    input  logic [R-1:0]   out_ready,
    input  logic [R*T-1:0] in_data,
    input  logic [R-1:0]   in_valid,
    output logic [R-1:0]   in_ready,
    output logic           irq
);

    localparam logic [A-1:0] ADDR_STAT_OUT = A'(ofs_stat_out(R));
    localparam logic [A-1:0] ADDR_STAT_IN  = A'(ofs_stat_in(R));
    localparam logic [A-1:0] ADDR_OVR      = A'(ofs_ovr(R));
    localparam logic [A-1:0] ADDR_IEN      = A'(ofs_ien(R));

    logic [R-1:0] wr_sel;
    logic [R-1:0] rd_clr;
    logic [R-1:0] ovr_clr;
    logic [R-1:0] in_full;
    logic [R-1:0] in_full_nxt;
    logic [R-1:0] ovr;
    logic [R-1:0] ien;
    logic [R-1:0] ien_nxt;
    logic [T-1:0] in_q [R];
    logic [T-1:0] rd_mux;

    for (genvar g = 0; g < R; g++) begin : g_ch
        localparam logic [A-1:0] ADDR_DATA = A'(g);

        assign wr_sel[g] = cpu_we & (cpu_addr == ADDR_DATA);
        assign rd_clr[g] = cpu_re & (cpu_addr == ADDR_DATA);

        io_channel #(
            .T(T)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wr_sel     (wr_sel[g]),
            .rd_clr     (rd_clr[g]),
            .ovr_clr    (ovr_clr[g]),
            .wdata      (cpu_wdata),
            .out_ready  (out_ready[g]),
            .in_valid   (in_valid[g]),
            .in_data    (in_data[g*T +: T]),
            .out_data   (out_data[g*T +: T]),
            .out_valid  (out_valid[g]),
            .in_q       (in_q[g]),
            .in_full    (in_full[g]),
            .in_full_nxt(in_full_nxt[g]),
            .ovr        (ovr[g])
        );
    end

    assign in_ready = ~in_full;

    always_comb begin
        ovr_clr = '0;
        ien_nxt = ien;
        if (cpu_we && (cpu_addr == ADDR_OVR)) begin
            ovr_clr = cpu_wdata[R-1:0];
        end
        if (cpu_we && (cpu_addr == ADDR_IEN)) begin
            ien_nxt = cpu_wdata[R-1:0];
        end
    end

    // Read mux uses current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < R; i++) begin
            if (cpu_addr == A'(i)) begin
                rd_mux = in_q[i];
            end
        end
        if (cpu_addr == ADDR_STAT_OUT) rd_mux = T'(out_valid);
        if (cpu_addr == ADDR_STAT_IN)  rd_mux = T'(in_full);
        if (cpu_addr == ADDR_OVR)      rd_mux = T'(ovr);
        if (cpu_addr == ADDR_IEN)      rd_mux = T'(ien);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            ien        <= '0;
            irq        <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_re;
            if (cpu_re) begin
                cpu_rdata <= rd_mux;
            end
            ien <= ien_nxt;
            // Built from next-state values so irq tracks in_full/ien with no extra lag.
            irq <= |(in_full_nxt & ien_nxt);
        end
    end

endmodule

// File: tb/tb_io_reg_bank.sv
module tb_io_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic        cpu_re;
    logic [2:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] out_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [15:0] in_data;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
    } sb_entry_t;

    sb_entry_t exp_q[$];

    typedef struct {
        logic [2:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[8];

    io_reg_bank #(.R(2), .T(8), .A(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input string name, input logic [2:0] a, input logic [7:0] e);
        sb_entry_t ent;
        ent.name = name;
        ent.data = e;
        exp_q.push_back(ent);
        cpu_re   = 1'b1;
        cpu_addr = a;
        tick();
        cpu_re   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"},  32'(out_data),   32'h0);
        check({tag, "_out_valid"}, 32'(out_valid),  32'h0);
        check({tag, "_in_ready"},  32'(in_ready),   32'h3);
        check({tag, "_irq"},       32'(irq),        32'h0);
        check({tag, "_rvalid"},    32'(cpu_rvalid), 32'h0);
        check({tag, "_rdata"},     32'(cpu_rdata),  32'h0);
    endtask

    // Scoreboard: every rvalid pops the oldest expected read.
    initial begin
        sb_entry_t ent;
        forever begin
            @(negedge clk);
            if (cpu_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected: got rdata 0x%0h with no read pending", cpu_rdata);
                end else begin
                    ent = exp_q.pop_front();
                    check(ent.name, 32'(cpu_rdata), 32'(ent.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
        out_ready = 0; in_data = 0; in_valid = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #5;
        check_reset_outputs("rst");
        tick();
        rst = 1'b1;

        // Every address reads 0 out of reset.
        for (int i = 0; i < 8; i++) begin
            vecs[i].addr = 3'(i);
            vecs[i].exp  = 8'h00;
        end
        for (int i = 0; i < 8; i++) begin
            cpu_read($sformatf("rst_rd_a%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Output write, overrun, W1C.
        cpu_write(3'd0, 8'h41);
        check("wr0_out_data", 32'(out_data[7:0]), 32'h41);
        check("wr0_out_valid", 32'(out_valid), 32'h1);
        cpu_write(3'd0, 8'h42);
        check("drop_out_data", 32'(out_data[7:0]), 32'h41);
        cpu_read("ovr_set", 3'd4, 8'h01);
        cpu_read("stat_out", 3'd2, 8'h01);
        cpu_write(3'd4, 8'h01);
        cpu_read("ovr_clr", 3'd4, 8'h00);

        // Write while draining keeps valid high.
        cpu_write(3'd1, 8'h33);
        check("wr1_out_valid", 32'(out_valid), 32'h3);
        out_ready = 2'b10;
        cpu_write(3'd1, 8'h55);
        out_ready = 2'b00;
        check("drain_wr_data", 32'(out_data), 32'h5541);
        check("drain_wr_valid", 32'(out_valid), 32'h3);
        cpu_read("ovr_none", 3'd4, 8'h00);
        out_ready = 2'b11;
        tick();
        out_ready = 2'b00;
        check("consume_valid", 32'(out_valid), 32'h0);
        check("consume_data", 32'(out_data), 32'h5541);

        // Input capture and read-clear.
        in_data  = 16'h7E00;
        in_valid = 2'b10;
        tick();
        in_valid = 2'b00;
        check("cap1_in_ready", 32'(in_ready), 32'h1);
        check("cap1_irq_off", 32'(irq), 32'h0);
        cpu_read("stat_in", 3'd3, 8'h02);
        cpu_read("rd_data1", 3'd1, 8'h7E);
        check("rd1_in_ready", 32'(in_ready), 32'h3);
        cpu_read("rd_data1_empty", 3'd1, 8'h7E);
        check("rd1e_in_ready", 32'(in_ready), 32'h3);

        // Interrupt.
        cpu_write(3'd5, 8'h01);
        in_data  = 16'h0010;
        in_valid = 2'b01;
        tick();
        in_valid = 2'b00;
        check("irq_set", 32'(irq), 32'h1);
        check("irq_in_ready", 32'(in_ready), 32'h2);
        cpu_read("rd_data0", 3'd0, 8'h10);
        check("irq_clr", 32'(irq), 32'h0);

        // Simultaneous write and read returns the pre-write value.
        begin
            sb_entry_t ent;
            ent.name = "we_re_ien";
            ent.data = 8'h01;
            exp_q.push_back(ent);
        end
        cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 3'd5; cpu_wdata = 8'h00;
        tick();
        cpu_we = 1'b0; cpu_re = 1'b0;
        cpu_read("ien_after", 3'd5, 8'h00);

        // Data offered while full is not captured.
        in_data  = 16'h00AA;
        in_valid = 2'b01;
        tick();
        in_data  = 16'h00BB;
        tick();
        in_valid = 2'b00;
        check("full_in_ready", 32'(in_ready), 32'h2);
        cpu_read("full_hold", 3'd0, 8'hAA);

        // Asynchronous reset mid-transfer.
        cpu_write(3'd0, 8'hA5);
        cpu_write(3'd1, 8'h5A);
        check("pre_rst_valid", 32'(out_valid), 32'h3);
        check("pre_rst_data", 32'(out_data), 32'h5AA5);
        out_ready = 2'b11;
        in_data   = 16'h0033;
        in_valid  = 2'b01;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async");
        tick();
        check_reset_outputs("hold");
        out_ready = 2'b00;
        in_valid  = 2'b00;
        rst = 1'b1;
        cpu_read("post_rst_data0", 3'd0, 8'h00);
        cpu_read("post_rst_stat_in", 3'd3, 8'h00);
        cpu_read("post_rst_ien", 3'd5, 8'h00);

        repeat (3) tick();
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
